// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : int_arbiter
// Description : Four-source fixed-priority interrupt arbiter with edge-latched
//               pending bits and an IDLE/REQ/GAP handshake to the processor.
//               Optional acknowledge timeout enabled by INT_ACK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module int_arbiter #(
    parameter logic [7:0] TO_LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] src,
    input  logic [3:0] mask,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [1:0] int_id,
    output logic [3:0] pending,
    output logic       timeout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [3:0] r_src_q;
    logic       r_src_armed;
    logic [3:0] r_pending;
    logic [1:0] r_int_id;

    logic [3:0] w_rise;
    logic [3:0] w_req_vec;
    logic [3:0] w_clr;
    logic [1:0] w_sel_id;
    logic       w_sel_vld;
    logic       w_enter_req;
    logic       w_ack;
    logic       w_expire;

    // The first clock after reset only loads the src history, so a level
    // already high at release never looks like a rising edge.
    assign w_rise      = r_src_armed ? (src & ~r_src_q) : 4'b0000;
    assign w_req_vec   = r_pending & mask;
    assign w_sel_vld   = |w_req_vec;
    assign w_enter_req = (r_state == c_IDLE) && w_sel_vld;
    assign w_ack       = (r_state == c_REQ) && interrupt_ack;
    assign w_clr       = w_ack ? (4'b0001 << r_int_id) : 4'b0000;

    always_comb begin
        w_sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_req_vec[i]) begin
                w_sel_id = i[1:0];
            end
        end
    end

`ifdef INT_ACK_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_timeout;
    logic [8:0] w_to_cnt_inc;

    assign w_to_cnt_inc = {1'b0, r_to_cnt} + 9'd1;
    // An ack in the same cycle always takes precedence over expiry.
    assign w_expire = (r_state == c_REQ) && !interrupt_ack
                      && (w_to_cnt_inc >= {1'b0, TO_LIMIT});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt  <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enter_req) begin
                r_to_cnt <= 8'd0;
            end else if (r_state == c_REQ) begin
                r_to_cnt <= w_to_cnt_inc[7:0];
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_to_limit;

    assign w_unused_to_limit = ^TO_LIMIT;
    assign w_expire          = 1'b0;
    assign timeout           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_sel_vld) w_state_nxt = c_REQ;
            c_REQ:   if (w_ack || w_expire) w_state_nxt = c_GAP;
            c_GAP:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        interrupt = (r_state == c_REQ);
    end

    // A new edge on the bit being acknowledged wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_q     <= 4'b0000;
            r_src_armed <= 1'b0;
            r_pending   <= 4'b0000;
            r_int_id    <= 2'd0;
        end else begin
            r_src_q     <= src;
            r_src_armed <= 1'b1;
            r_pending   <= (r_pending & ~w_clr) | w_rise;
            if (w_enter_req) begin
                r_int_id <= w_sel_id;
            end
        end
    end

    assign int_id  = r_int_id;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_arbiter
// Description : Self-checking bench for int_arbiter: directed vector table,
//               reset/timeout sequences and random stimulus vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_arbiter;

    localparam logic [7:0] c_TO_LIMIT = 8'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic [3:0] mask;
    logic       interrupt_ack;
    logic       interrupt;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    int_arbiter #(.TO_LIMIT(c_TO_LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .src           (src),
        .mask          (mask),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
        .int_id        (int_id),
        .pending       (pending),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic [3:0] mask;
        logic       ack;
        logic       exp_int;
        logic [1:0] exp_id;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a service slot that is busy, in its gap, or free.
    bit [3:0] m_pend;
    bit [3:0] m_prev;
    bit       m_armed;
    bit       m_busy;
    bit       m_gap;
    int       m_id;
    int       m_age;
    bit       m_to;

    function automatic void model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_armed = 1'b0;
        m_busy  = 1'b0;
        m_gap   = 1'b0;
        m_id    = 0;
        m_age   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step();
        bit [3:0] rise;
        int       clr_id;
        clr_id = -1;
        for (int i = 0; i < 4; i++) rise[i] = m_armed && src[i] && !m_prev[i];
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (interrupt_ack) begin
                clr_id = m_id;
                m_busy = 1'b0;
                m_gap  = 1'b1;
            end
`ifdef INT_ACK_TIMEOUT_EN
            else if (m_age >= int'(c_TO_LIMIT)) begin
                m_to   = 1'b1;
                m_busy = 1'b0;
                m_gap  = 1'b1;
            end
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && mask[i]) begin
                    m_busy = 1'b1;
                    m_id   = i;
                    m_age  = 0;
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i == clr_id) m_pend[i] = 1'b0;
            if (rise[i])     m_pend[i] = 1'b1;
        end
        m_prev  = src;
        m_armed = 1'b1;
    endfunction

    function automatic void check(input string name, input logic [7:0] act,
                                  input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model(input string tag);
        check({tag, ".interrupt"}, {7'd0, interrupt}, {7'd0, m_busy});
        check({tag, ".int_id"},    {6'd0, int_id},    8'(m_id));
        check({tag, ".pending"},   {4'd0, pending},   {4'd0, m_pend});
        check({tag, ".timeout"},   {7'd0, timeout},   {7'd0, m_to});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic void add(input logic [3:0] s, input logic [3:0] m, input logic a,
                                input logic i, input logic [1:0] id, input logic [3:0] p);
        vec_t v;
        v.src = s; v.mask = m; v.ack = a; v.exp_int = i; v.exp_id = id; v.exp_pend = p;
        tbl.push_back(v);
    endfunction

    initial begin
        int hi;
        reset = 1'b0;
        src = 4'h0; mask = 4'hF; interrupt_ack = 1'b0;
        model_reset();

        //   src      mask  ack int id  pending
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000);
        add(4'b0100, 4'hF, 0, 0, 0, 4'b0100);
        add(4'b0100, 4'hF, 0, 1, 2, 4'b0100);
        add(4'b0100, 4'hF, 1, 0, 2, 4'b0000);
        add(4'b0100, 4'hF, 0, 0, 2, 4'b0000);
        add(4'b0100, 4'hF, 1, 0, 2, 4'b0000);
        add(4'b1010, 4'hF, 0, 0, 2, 4'b1010);
        add(4'b1010, 4'hF, 0, 1, 1, 4'b1010);
        add(4'b1010, 4'hF, 1, 0, 1, 4'b1000);
        add(4'b1010, 4'hF, 1, 0, 1, 4'b1000);
        add(4'b1010, 4'hF, 0, 1, 3, 4'b1000);
        add(4'b1010, 4'hF, 1, 0, 3, 4'b0000);
        add(4'b0000, 4'hF, 0, 0, 3, 4'b0000);
        add(4'b0001, 4'hF, 0, 0, 3, 4'b0001);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001);
        add(4'b0001, 4'hF, 1, 0, 0, 4'b0001);
        add(4'b0001, 4'hF, 0, 0, 0, 4'b0001);
        add(4'b0001, 4'hF, 0, 1, 0, 4'b0001);
        add(4'b0001, 4'hF, 1, 0, 0, 4'b0000);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000);
        add(4'b0000, 4'hE, 0, 0, 0, 4'b0000);
        add(4'b0001, 4'hE, 0, 0, 0, 4'b0001);
        add(4'b0001, 4'hE, 1, 0, 0, 4'b0001);
        add(4'b0001, 4'hE, 0, 0, 0, 4'b0001);
        add(4'b0001, 4'hF, 0, 1, 0, 4'b0001);
        add(4'b0011, 4'h0, 0, 1, 0, 4'b0011);
        add(4'b0011, 4'h0, 1, 0, 0, 4'b0010);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0010);
        add(4'b0000, 4'hF, 0, 1, 1, 4'b0010);
        add(4'b0000, 4'hF, 1, 0, 1, 4'b0000);
        add(4'b0000, 4'hF, 0, 0, 1, 4'b0000);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.interrupt", {7'd0, interrupt}, 8'd0);
        check("rst.int_id",    {6'd0, int_id},    8'd0);
        check("rst.pending",   {4'd0, pending},   8'd0);
        check("rst.timeout",   {7'd0, timeout},   8'd0);
        reset = 1'b1;

        // Directed vector table
        foreach (tbl[k]) begin
            src = tbl[k].src; mask = tbl[k].mask; interrupt_ack = tbl[k].ack;
            tick();
            check($sformatf("tbl%0d.interrupt", k), {7'd0, interrupt}, {7'd0, tbl[k].exp_int});
            check($sformatf("tbl%0d.int_id", k),    {6'd0, int_id},    {6'd0, tbl[k].exp_id});
            check($sformatf("tbl%0d.pending", k),   {4'd0, pending},   {4'd0, tbl[k].exp_pend});
            check($sformatf("tbl%0d.timeout", k),   {7'd0, timeout},   8'd0);
        end
        interrupt_ack = 1'b0;

        // Reset in the middle of REQ, src held high through release
        src = 4'b0100;
        tick();
        tick();
        check("midreq.interrupt_before", {7'd0, interrupt}, 8'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("midreq.interrupt_async", {7'd0, interrupt}, 8'd0);
        check("midreq.pending_async",   {4'd0, pending},   8'd0);
        check("midreq.int_id_async",    {6'd0, int_id},    8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_model("release");
            check("release.no_irq", {7'd0, interrupt}, 8'd0);
        end

        // Ack withheld: timeout path or indefinite wait
        src = 4'b0000;
        tick();
        src = 4'b0010;
        tick();
        tick();
        check("hold.interrupt_up", {7'd0, interrupt}, 8'd1);
        hi = 1;
        for (int k = 0; k < 20 && interrupt; k++) begin
            tick();
            check_model("hold");
            if (interrupt) hi++;
        end
`ifdef INT_ACK_TIMEOUT_EN
        check("to.req_cycles", 8'(hi), c_TO_LIMIT);
        check("to.timeout",    {7'd0, timeout}, 8'd1);
        check("to.pending",    {4'd0, pending}, 8'b0010);
        tick();
        check("to.gap_low",    {7'd0, interrupt}, 8'd0);
        tick();
        check("to.rereq",      {7'd0, interrupt}, 8'd1);
        check("to.rereq_id",   {6'd0, int_id},    8'd1);
`else
        check("noto.req_cycles", 8'(hi), 8'd21);
        check("noto.timeout",    {7'd0, timeout}, 8'd0);
`endif
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        check_model("hold.done");

        // Random stimulus vs. model, with occasional asynchronous resets
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) src[b] = ~src[b];
            end
            if ($urandom_range(15) == 0) mask = 4'($urandom_range(15));
            interrupt_ack = ($urandom_range(3) == 0);
            if ($urandom_range(149) == 0) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_model("rand.rst");
                @(negedge clk);
                reset = 1'b1;
            end
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter TO_LIMIT, default 255: acknowledge-timeout limit in clk cycles, 8-bit; used only when INT_ACK_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 src  input  4  interrupt request levels from peripherals; bit 0 has highest priority.
REQ-005 mask  input  4  per-source enable, 1 = enabled; a masked source still latches pending.
REQ-006 interrupt_ack  input  1  single-cycle acknowledge pulse from the processor.
REQ-007 interrupt  output  1  interrupt request to the processor.
REQ-008 int_id  output  2  index of the source currently being serviced.
REQ-009 pending  output  4  latched pending bits.
REQ-010 timeout  output  1  sticky flag: an acknowledge timed out.

Function
REQ-011 Each src bit SHALL be registered once; a rising edge (registered 0, current 1) SHALL set the matching pending bit on the next clock.
REQ-012 States SHALL be IDLE, REQ and GAP.
REQ-013 IDLE: when (pending & mask) is non-zero, SHALL latch the lowest set index into int_id and move to REQ; interrupt rises in the same cycle that REQ is entered.
REQ-014 REQ: interrupt SHALL be 1; int_id SHALL hold steady; pending changes SHALL NOT re-arbitrate.
REQ-015 REQ with interrupt_ack=1: SHALL clear pending[int_id] and move to GAP.
REQ-016 GAP: interrupt SHALL be 0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-017 interrupt_ack outside REQ SHALL be ignored.
REQ-018 A new edge on the same bit that is being cleared in the same cycle: set SHALL win, so the bit stays 1.
REQ-019 Edges on other bits during REQ or GAP SHALL latch normally.
REQ-020 Minimum back-to-back service SHALL be 3 cycles from one interrupt rise to the next: REQ, GAP, IDLE.
REQ-021 Clearing mask bits during REQ SHALL NOT abort the in-flight request.

Reset
REQ-022 reset=0 SHALL force, asynchronously: state=IDLE, interrupt=0, int_id=0, pending=0, timeout=0, src registers=0, timeout counter=0.
REQ-023 Reset during REQ SHALL drop interrupt immediately and discard all pending bits.
REQ-024 A src level already high at reset release SHALL NOT count as an edge.

Configuration
REQ-025 Macro INT_ACK_TIMEOUT_EN defined: an 8-bit counter SHALL count cycles in REQ and clear on entry to REQ.
REQ-026 When the counter reaches TO_LIMIT without an ack, the block SHALL set timeout, leave pending[int_id] set and go to GAP.
REQ-027 Ack and timeout in the same cycle: the ack SHALL win.
REQ-028 timeout SHALL clear only on reset.
REQ-029 Macro INT_ACK_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be tied to 0, and REQ SHALL wait indefinitely.

Verification
REQ-030 mask=4'hF; src[2] rises -> pending=4'b0100 next clock, interrupt=1 and int_id=2 one clock later; ack -> pending=0, interrupt low for 1 cycle.
REQ-031 src[3] and src[1] rise in the same cycle -> int_id=1 serviced first; after ack and GAP, int_id=3 requested; total 3 cycles between interrupt rises.
REQ-032 Ack cycle coincides with a new src[int_id] edge -> pending bit remains 1, and the same id is re-requested after GAP.
REQ-033 mask=4'b1110, src[0] rises -> pending[0]=1, interrupt stays 0; setting mask[0]=1 -> interrupt=1 and int_id=0 on the next clock.
REQ-034 reset pulsed low mid-REQ -> interrupt=0 and pending=0 immediately; src held high through reset release -> no new interrupt.
REQ-035 INT_ACK_TIMEOUT_EN defined, TO_LIMIT=4, no ack -> interrupt drops after 4 REQ cycles, timeout=1, pending bit retained, source re-requested.
